// File: rtl/rs_syndrome.sv
// rs_syndrome
// -----------------------------------------------------------------------------
// First stage of the RS(544,514) decoder over GF(2^10) (field polynomial
// x^10 + x^3 + 1, alpha = 10'h002). It accumulates the 30 syndromes
// S_i = r(alpha^i), i = 0..29, of each received codeword with Horner's rule.
// Symbols arrive highest degree first, at up to one symbol per cycle, with
// optional stalls. All syndromes are presented in parallel one cycle after
// the last symbol.
//
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous reset, active low
//   sop       : start of codeword, qualified by valid_in
//   valid_in  : data_in carries a received symbol this cycle
//   data_in   : received symbol, x^543 coefficient first
//   syn_valid : one-cycle pulse, syn_out / err_det updated
//   syn_out   : packed syndromes, S_i in bits [10*i+9 : 10*i]
//   err_det   : at least one syndrome of the last reported word is nonzero
//   sync_err  : one-cycle pulse, a partial codeword was aborted by sop
//   busy      : a codeword is partially received
// -----------------------------------------------------------------------------
module rs_syndrome #(
    parameter int N     = 544,
    parameter int NSYM  = 30,
    parameter int CNT_W = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sop,
    input  logic                 valid_in,
    input  logic [9:0]           data_in,
    output logic                 syn_valid,
    output logic [NSYM*10-1:0]   syn_out,
    output logic                 err_det,
    output logic                 sync_err,
    output logic                 busy
);

    typedef enum logic {
        IDLE,
        ACC
    } state_t;

    // Multiply by x modulo x^10 + x^3 + 1 (x^10 folds back to x^3 + 1).
    function automatic logic [9:0] gf_xtime(input logic [9:0] v);
        return {v[8:0], 1'b0} ^ (v[9] ? 10'h009 : 10'h000);
    endfunction

    // Shift-and-add field multiply. Used with a constant second operand, so
    // each instance collapses to a small XOR network.
    function automatic logic [9:0] gf_mul(input logic [9:0] a, input logic [9:0] b);
        logic [9:0] p;
        p = '0;
        for (int k = 9; k >= 0; k--) begin
            p = gf_xtime(p);
            if (b[k]) begin
                p = p ^ a;
            end
        end
        return p;
    endfunction

    // alpha^n, evaluated at elaboration time to build the multiplier constants.
    function automatic logic [9:0] alpha_pow(input int n);
        logic [9:0] v;
        v = 10'h001;
        for (int k = 0; k < n; k++) begin
            v = gf_xtime(v);
        end
        return v;
    endfunction

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [9:0]         acc_q [NSYM];
    logic [9:0]         horner [NSYM];
    logic [NSYM*10-1:0] horner_flat;

    logic               start_word;
    logic               step_word;
    logic               finish_word;
    logic               abort_word;

    // One fixed-constant multiplier per syndrome: next S_i = S_i*alpha^i ^ r.
    // The flattened copy is what gets registered when the word completes.
    for (genvar i = 0; i < NSYM; i++) begin : g_horner
        localparam logic [9:0] ALPHA_I = alpha_pow(i);
        assign horner[i]                = gf_mul(acc_q[i], ALPHA_I) ^ data_in;
        assign horner_flat[10*i +: 10]  = horner[i];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control. A sop in ACC always restarts the word,
    // even when it coincides with what would have been the last symbol, so an
    // aborted word can never be reported.
    always_comb begin
        state_d     = state_q;
        start_word  = 1'b0;
        step_word   = 1'b0;
        finish_word = 1'b0;
        abort_word  = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in && sop) begin
                    start_word = 1'b1;
                    state_d    = ACC;
                end
            end
            ACC: begin
                if (valid_in) begin
                    if (sop) begin
                        abort_word = 1'b1;
                        start_word = 1'b1;
                    end else if (cnt_q == CNT_W'(N - 1)) begin
                        finish_word = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        step_word = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Accumulators and symbol counter. Stall cycles fall through and hold.
    // Completion clears everything so the next sop starts from a clean slate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            for (int i = 0; i < NSYM; i++) begin
                acc_q[i] <= '0;
            end
        end else if (start_word) begin
            cnt_q <= CNT_W'(1);
            for (int i = 0; i < NSYM; i++) begin
                acc_q[i] <= data_in;
            end
        end else if (step_word) begin
            cnt_q <= cnt_q + CNT_W'(1);
            for (int i = 0; i < NSYM; i++) begin
                acc_q[i] <= horner[i];
            end
        end else if (finish_word) begin
            cnt_q <= '0;
            for (int i = 0; i < NSYM; i++) begin
                acc_q[i] <= '0;
            end
        end
    end

    // Output registers. syn_out and err_det hold until the next completed
    // word; the two status strobes are single-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syn_valid <= 1'b0;
            sync_err  <= 1'b0;
            syn_out   <= '0;
            err_det   <= 1'b0;
        end else begin
            syn_valid <= finish_word;
            sync_err  <= abort_word;
            if (finish_word) begin
                syn_out <= horner_flat;
                err_det <= |horner_flat;
            end
        end
    end

    assign busy = (state_q == ACC);

endmodule

// File: tb/tb_rs_syndrome.sv
// tb_rs_syndrome
// -----------------------------------------------------------------------------
// Directed bench for rs_syndrome. Codewords are built by a table-based RS
// encoder in the bench; expected syndromes come either from hand values or
// from direct power-sum evaluation S_i = sum r_d * alpha^(i*d) using
// log/antilog tables.
// -----------------------------------------------------------------------------
module tb_rs_syndrome;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sop;
    logic         valid_in;
    logic [9:0]   data_in;
    logic         syn_valid;
    logic [299:0] syn_out;
    logic         err_det;
    logic         sync_err;
    logic         busy;

    int checks_total = 0;
    int checks_failed = 0;

    logic [9:0] exp_t [0:1022];
    int         log_t [0:1023];
    logic [9:0] gpoly [0:30];
    logic [9:0] bank  [0:3][0:543];

    logic [299:0] sv_q[$];
    logic         sv_err_q[$];
    longint       sv_time_q[$];
    int           se_count = 0;

    rs_syndrome dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sop       (sop),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .syn_valid (syn_valid),
        .syn_out   (syn_out),
        .err_det   (err_det),
        .sync_err  (sync_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Record every reported word (value, flag, time) and every sync error.
    always @(negedge clk) begin
        if (syn_valid === 1'b1) begin
            sv_q.push_back(syn_out);
            sv_err_q.push_back(err_det);
            sv_time_q.push_back($time);
        end
        if (sync_err === 1'b1) begin
            se_count++;
        end
    end

    function automatic logic [9:0] gmul(input logic [9:0] a, input logic [9:0] b);
        if (a == 10'h000 || b == 10'h000) return 10'h000;
        return exp_t[(log_t[a] + log_t[b]) % 1023];
    endfunction

    // Direct evaluation of all 30 syndromes of bank[w].
    function automatic logic [299:0] modelSyn(input int w);
        logic [299:0] r;
        logic [9:0]   s;
        r = '0;
        for (int i = 0; i < 30; i++) begin
            s = 10'h000;
            for (int p = 0; p < 544; p++) begin
                s = s ^ gmul(bank[w][p], exp_t[(i * (543 - p)) % 1023]);
            end
            r[10*i +: 10] = s;
        end
        return r;
    endfunction

    // Systematic encoder: random message, then remainder of m(x)x^30 mod g(x).
    task automatic encodeWord(input int w);
        logic [9:0] par [0:29];
        logic [9:0] fb;
        for (int k = 0; k < 30; k++) par[k] = 10'h000;
        for (int p = 0; p < 514; p++) begin
            bank[w][p] = 10'($urandom_range(1023, 0));
            fb = bank[w][p] ^ par[29];
            for (int k = 29; k >= 1; k--) begin
                par[k] = par[k-1] ^ gmul(fb, gpoly[k]);
            end
            par[0] = gmul(fb, gpoly[0]);
        end
        for (int k = 0; k < 30; k++) bank[w][514 + k] = par[29 - k];
    endtask

    task automatic clearWord(input int w);
        for (int p = 0; p < 544; p++) bank[w][p] = 10'h000;
    endtask

    // Stream the first nsym symbols of bank[w], sop on the first, with up to
    // max_gap idle cycles (random data) before every symbol after the first.
    task automatic applyStimulus(input int w, input int nsym, input int max_gap,
                                 output int gaps, output longint t_first);
        int gap_n;
        gaps = 0;
        t_first = 0;
        for (int p = 0; p < nsym; p++) begin
            gap_n = (max_gap > 0 && p > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int k = 0; k < gap_n; k++) begin
                @(negedge clk);
                valid_in = 1'b0;
                sop      = 1'b0;
                data_in  = 10'($urandom_range(1023, 0));
            end
            gaps += gap_n;
            @(negedge clk);
            if (p == 0) t_first = $time;
            valid_in = 1'b1;
            sop      = (p == 0);
            data_in  = bank[w][p];
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            valid_in = 1'b0;
            sop      = 1'b0;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [299:0] obs,
                               input logic [299:0] expv);
        checks_total++;
        assert (obs === expv) else begin
            checks_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    initial begin
        logic [9:0]   v;
        logic [299:0] e;
        int           n0;
        int           se0;
        int           gaps;
        longint       t0;
        longint       t1;

        // Antilog/log tables and the generator polynomial prod (x + alpha^i).
        v = 10'h001;
        log_t[0] = 0;
        for (int k = 0; k < 1023; k++) begin
            exp_t[k] = v;
            log_t[v] = k;
            v = {v[8:0], 1'b0} ^ (v[9] ? 10'h009 : 10'h000);
        end
        for (int k = 0; k <= 30; k++) gpoly[k] = 10'h000;
        gpoly[0] = 10'h001;
        for (int i = 0; i < 30; i++) begin
            for (int k = i + 1; k >= 1; k--) begin
                gpoly[k] = gpoly[k-1] ^ gmul(gpoly[k], exp_t[i]);
            end
            gpoly[0] = gmul(gpoly[0], exp_t[i]);
        end

        // Reset state.
        rst_n = 1'b1; sop = 1'b0; valid_in = 1'b0; data_in = 10'h000;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_syn_valid", syn_valid, 0);
        checkOutput("rst_syn_out", syn_out, 0);
        checkOutput("rst_err_det", err_det, 0);
        checkOutput("rst_sync_err", sync_err, 0);
        checkOutput("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // All-zero codeword.
        clearWord(0);
        n0 = sv_q.size();
        applyStimulus(0, 544, 0, gaps, t0);
        checkOutput("zero_busy_mid", busy, 1);
        idle(3);
        checkOutput("zero_count", sv_q.size() - n0, 1);
        checkOutput("zero_latency", sv_time_q[n0], t0 + 5440);
        checkOutput("zero_syn", sv_q[n0], 0);
        checkOutput("zero_err", sv_err_q[n0], 0);
        checkOutput("zero_sync_err", se_count, 0);
        checkOutput("zero_busy_after", busy, 0);

        // Three back-to-back encoded codewords.
        for (int w = 1; w <= 3; w++) encodeWord(w);
        n0 = sv_q.size();
        applyStimulus(1, 544, 0, gaps, t0);
        applyStimulus(2, 544, 0, gaps, t1);
        applyStimulus(3, 544, 0, gaps, t1);
        idle(3);
        checkOutput("b2b_count", sv_q.size() - n0, 3);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("b2b_syn%0d", k), sv_q[n0 + k], modelSyn(k + 1));
            checkOutput($sformatf("b2b_err%0d", k), sv_err_q[n0 + k], 0);
            checkOutput($sformatf("b2b_time%0d", k), sv_time_q[n0 + k], t0 + (k + 1) * 5440);
        end
        checkOutput("b2b_sync_err", se_count, 0);

        // Zero word with last symbol 5: every S_i = 5.
        clearWord(0);
        bank[0][543] = 10'h005;
        n0 = sv_q.size();
        applyStimulus(0, 544, 0, gaps, t0);
        idle(3);
        e = {30{10'h005}};
        checkOutput("last5_syn", sv_q[n0], e);
        checkOutput("last5_err", sv_err_q[n0], 1);

        // Zero word with first symbol 1: S_i = alpha^(543*i).
        clearWord(0);
        bank[0][0] = 10'h001;
        n0 = sv_q.size();
        applyStimulus(0, 544, 0, gaps, t0);
        idle(3);
        e = sv_q[n0];
        checkOutput("first1_s0", e[9:0], 10'h001);
        checkOutput("first1_s1", e[19:10], exp_t[543]);
        checkOutput("first1_all", e, modelSyn(0));
        checkOutput("first1_err", sv_err_q[n0], 1);

        // Reset in the middle of a word, then a clean word.
        encodeWord(1);
        n0 = sv_q.size();
        se0 = se_count;
        applyStimulus(1, 300, 0, gaps, t0);
        checkOutput("midrst_busy_before", busy, 1);
        @(negedge clk);
        valid_in = 1'b0;
        sop = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_syn_out", syn_out, 0);
        checkOutput("midrst_err_det", err_det, 0);
        checkOutput("midrst_syn_valid", syn_valid, 0);
        checkOutput("midrst_sync_err", sync_err, 0);
        checkOutput("midrst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        checkOutput("midrst_no_report", sv_q.size() - n0, 0);
        applyStimulus(1, 544, 0, gaps, t0);
        idle(3);
        checkOutput("midrst_count", sv_q.size() - n0, 1);
        checkOutput("midrst_syn", sv_q[n0], modelSyn(1));
        checkOutput("midrst_err", sv_err_q[n0], 0);
        checkOutput("midrst_no_sync_err", se_count - se0, 0);

        // Stray symbols in IDLE, then an encoded word with random gaps.
        encodeWord(2);
        n0 = sv_q.size();
        se0 = se_count;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            valid_in = 1'b1;
            sop = 1'b0;
            data_in = 10'h3A5 ^ 10'(k);
        end
        applyStimulus(2, 544, 5, gaps, t0);
        idle(3);
        checkOutput("gap_count", sv_q.size() - n0, 1);
        checkOutput("gap_syn", sv_q[n0], modelSyn(2));
        checkOutput("gap_err", sv_err_q[n0], 0);
        checkOutput("gap_latency", sv_time_q[n0], t0 + (544 + gaps) * 10);
        checkOutput("gap_sync_err", se_count - se0, 0);

        // Early sop at symbol 200 aborts the partial word.
        encodeWord(1);
        encodeWord(3);
        n0 = sv_q.size();
        se0 = se_count;
        applyStimulus(1, 200, 0, gaps, t1);
        applyStimulus(3, 544, 0, gaps, t0);
        idle(3);
        checkOutput("early_sync_err", se_count - se0, 1);
        checkOutput("early_count", sv_q.size() - n0, 1);
        checkOutput("early_syn", sv_q[n0], modelSyn(3));
        checkOutput("early_err", sv_err_q[n0], 0);
        checkOutput("early_latency", sv_time_q[n0], t0 + 5440);

        $display("%0d/%0d checks passed", checks_total - checks_failed, checks_total);
        $finish;
    end

endmodule
